serial_capture_buffer: RTL and testbench

SERIAL_CAPTURE_BUFFER -- requirements
Module: serial_capture_buffer

---
 rtl/serial_capture_buffer.sv | 145 ++++++++++++++
 tb/tb_serial_capture_buffer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_capture_buffer.sv
// Strobed serial capture buffer: 1/2/4 lanes, MSB- or LSB-first fill.
// Optional timeout enabled by defining SERIAL_CAPTURE_TIMEOUT_EN.
module serial_capture_buffer #(
   parameter int BUF_SIZE = 8,
   parameter int LANES = 1,
   parameter int LSB_FIRST = 0,
`ifdef SERIAL_CAPTURE_TIMEOUT_EN
   parameter int TIMEOUT_CYCLES = 1024,
`endif
   localparam int MAX_STROBES = BUF_SIZE / LANES,
   localparam int CTR_W = $clog2(MAX_STROBES + 1)
) (
   input  logic                sys_clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic                read_sig,
   input  logic [LANES-1:0]    data_in,
   input  logic [CTR_W-1:0]    len,
   output logic [BUF_SIZE-1:0] data_out,
   output logic [CTR_W-1:0]    strobe_cnt,
   output logic                busy,
   output logic                done_sig,
   output logic                err
);

   typedef enum logic [1:0] {
      IDLE = 2'b01,
      READ = 2'b10
   } state_t;

   localparam logic [CTR_W-1:0] MAX_LEN = CTR_W'(MAX_STROBES);

   state_t             state, state_n;
   logic [BUF_SIZE-1:0] data_n;
   logic [CTR_W-1:0]   cnt_n;
   logic [CTR_W-1:0]   len_q, len_n;
   logic [CTR_W-1:0]   cnt_inc;
   logic               done_n;
   logic               err_n;

`ifdef SERIAL_CAPTURE_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0] tmo_q, tmo_n;
`endif

   assign busy    = (state == READ);
   assign cnt_inc = strobe_cnt + CTR_W'(1);

   // Next-state and next-register values for the capture FSM.
   always_comb begin
      state_n = state;
      data_n  = data_out;
      cnt_n   = strobe_cnt;
      len_n   = len_q;
      done_n  = done_sig;
      err_n   = err;
`ifdef SERIAL_CAPTURE_TIMEOUT_EN
      tmo_n   = tmo_q;
`endif
      case (state)
         IDLE: begin
            if (start && !abort) begin
               if (len == '0 || len > MAX_LEN)
                  len_n = MAX_LEN;
               else
                  len_n = len;
               data_n  = '0;
               cnt_n   = '0;
               done_n  = 1'b0;
               err_n   = 1'b0;
`ifdef SERIAL_CAPTURE_TIMEOUT_EN
               tmo_n   = '0;
`endif
               state_n = READ;
            end
         end
         READ: begin
            if (abort) begin
               state_n = IDLE;
            end else if (read_sig) begin
               if (LSB_FIRST != 0) begin
                  for (int i = 0; i < MAX_STROBES; i++)
                     if (strobe_cnt == CTR_W'(i))
                        data_n[i*LANES +: LANES] = data_in;
               end else begin
                  data_n = (data_out << LANES) | BUF_SIZE'(data_in);
               end
               cnt_n = cnt_inc;
`ifdef SERIAL_CAPTURE_TIMEOUT_EN
               tmo_n = '0;
`endif
               if (cnt_inc == len_q) begin
                  done_n  = 1'b1;
                  state_n = IDLE;
               end
            end
`ifdef SERIAL_CAPTURE_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
               err_n   = 1'b1;
               done_n  = 1'b0;
               state_n = IDLE;
            end else begin
               tmo_n = tmo_q + TMO_W'(1);
            end
`endif
         end
         default: begin
            state_n = IDLE;
            done_n  = 1'b0;
         end
      endcase
   end

   // State and capture registers; reset leaves a "completed" idle buffer.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         data_out   <= '0;
         strobe_cnt <= '0;
         len_q      <= MAX_LEN;
         done_sig   <= 1'b1;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         data_out   <= data_n;
         strobe_cnt <= cnt_n;
         len_q      <= len_n;
         done_sig   <= done_n;
         err        <= err_n;
      end
   end

`ifdef SERIAL_CAPTURE_TIMEOUT_EN
   // Idle-strobe counter for the READ timeout.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n)
         tmo_q <= '0;
      else
         tmo_q <= tmo_n;
   end
`endif

endmodule

// File: tb/tb_serial_capture_buffer.sv
// Scoreboard bench for serial_capture_buffer.
// Covers 8x1 MSB-first and 16x4 LSB-first builds.
module tb_serial_capture_buffer;

   logic sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   logic        rst_n;

   logic        start_a, abort_a, read_a;
   logic [0:0]  din_a;
   logic [3:0]  len_a;
   logic [7:0]  dout_a;
   logic [3:0]  cnt_a;
   logic        busy_a, done_a, err_a;

   logic        start_b, abort_b, read_b;
   logic [3:0]  din_b;
   logic [2:0]  len_b;
   logic [15:0] dout_b;
   logic [2:0]  cnt_b;
   logic        busy_b, done_b, err_b;

   serial_capture_buffer #(
      .BUF_SIZE(8),
      .LANES(1),
`ifdef SERIAL_CAPTURE_TIMEOUT_EN
      .TIMEOUT_CYCLES(16),
`endif
      .LSB_FIRST(0)
   ) u_dut (
      .sys_clk(sys_clk),
      .rst_n(rst_n),
      .start(start_a),
      .abort(abort_a),
      .read_sig(read_a),
      .data_in(din_a),
      .len(len_a),
      .data_out(dout_a),
      .strobe_cnt(cnt_a),
      .busy(busy_a),
      .done_sig(done_a),
      .err(err_a)
   );

   serial_capture_buffer #(
      .BUF_SIZE(16),
      .LANES(4),
      .LSB_FIRST(1)
   ) u_dut4 (
      .sys_clk(sys_clk),
      .rst_n(rst_n),
      .start(start_b),
      .abort(abort_b),
      .read_sig(read_b),
      .data_in(din_b),
      .len(len_b),
      .data_out(dout_b),
      .strobe_cnt(cnt_b),
      .busy(busy_b),
      .done_sig(done_b),
      .err(err_b)
   );

   typedef struct {
      logic [15:0] data;
      int          cnt;
      logic        done;
   } exp_t;

   exp_t sb[$];
   int   errs = 0;
   int   checks = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic wait_idle_a(input string tag);
      int w;
      w = 0;
      while (busy_a && w < 4) begin
         tick();
         w++;
      end
      check({tag, ":idle"}, 32'(busy_a), 32'd0);
   endtask

   // Drives one capture on the 8x1 instance; seq[15] is the first bit.
   task automatic cap8(input string tag, input int n_len,
                       input logic [15:0] seq, input int abort_after,
                       input bit poke_start);
      int          e_len, n;
      logic [7:0]  m;
      exp_t        e, g;
      e_len = (n_len == 0 || n_len > 8) ? 8 : n_len;
      n = (abort_after >= 0) ? abort_after : e_len;
      m = '0;
      for (int k = 0; k < n; k++)
         m = {m[6:0], seq[15-k]};
      e.data = 16'(m);
      e.cnt  = n;
      e.done = (abort_after < 0);
      sb.push_back(e);
      start_a = 1'b1;
      len_a   = 4'(n_len);
      tick();
      start_a = 1'b0;
      check({tag, ":st_busy"}, 32'(busy_a), 32'd1);
      check({tag, ":st_done"}, 32'(done_a), 32'd0);
      check({tag, ":st_cnt"}, 32'(cnt_a), 32'd0);
      for (int k = 0; k < n; k++) begin
         read_a = 1'b1;
         din_a  = seq[15-k];
         if (poke_start && k == 1)
            start_a = 1'b1;
         tick();
         read_a  = 1'b0;
         start_a = 1'b0;
         if (abort_after < 0 && k == n - 1) begin
            check({tag, ":fin_done"}, 32'(done_a), 32'd1);
            check({tag, ":fin_busy"}, 32'(busy_a), 32'd0);
         end else begin
            check({tag, ":mid_busy"}, 32'(busy_a), 32'd1);
            if (k % 2 == 1)
               tick();
         end
      end
      if (abort_after >= 0) begin
         abort_a = 1'b1;
         read_a  = 1'b1;
         din_a   = seq[15-n];
         tick();
         abort_a = 1'b0;
         read_a  = 1'b0;
      end
      wait_idle_a(tag);
      g = sb.pop_front();
      check({tag, ":data"}, 32'(dout_a), 32'(g.data));
      check({tag, ":cnt"}, 32'(cnt_a), 32'(g.cnt));
      check({tag, ":done"}, 32'(done_a), 32'(g.done));
      check({tag, ":err"}, 32'(err_a), 32'd0);
   endtask

   // Drives one capture on the 16x4 instance; nibble k is nibs[4k+:4].
   task automatic cap16(input string tag, input int n_len,
                        input logic [15:0] nibs);
      int          e_len, w;
      logic [15:0] m;
      exp_t        e, g;
      e_len = (n_len == 0 || n_len > 4) ? 4 : n_len;
      m = '0;
      for (int k = 0; k < e_len; k++)
         m[k*4 +: 4] = nibs[k*4 +: 4];
      e.data = m;
      e.cnt  = e_len;
      e.done = 1'b1;
      sb.push_back(e);
      start_b = 1'b1;
      len_b   = 3'(n_len);
      tick();
      start_b = 1'b0;
      check({tag, ":st_busy"}, 32'(busy_b), 32'd1);
      for (int k = 0; k < e_len; k++) begin
         read_b = 1'b1;
         din_b  = nibs[k*4 +: 4];
         tick();
         read_b = 1'b0;
         if (k == e_len - 1)
            check({tag, ":fin_done"}, 32'(done_b), 32'd1);
         else
            tick();
      end
      w = 0;
      while (busy_b && w < 4) begin
         tick();
         w++;
      end
      check({tag, ":idle"}, 32'(busy_b), 32'd0);
      g = sb.pop_front();
      check({tag, ":data"}, 32'(dout_b), 32'(g.data));
      check({tag, ":cnt"}, 32'(cnt_b), 32'(g.cnt));
      check({tag, ":done"}, 32'(done_b), 32'(g.done));
      check({tag, ":err"}, 32'(err_b), 32'd0);
   endtask

   initial begin
      rst_n   = 1'b0;
      start_a = 1'b0; abort_a = 1'b0; read_a = 1'b0;
      din_a   = '0;   len_a   = '0;
      start_b = 1'b0; abort_b = 1'b0; read_b = 1'b0;
      din_b   = '0;   len_b   = '0;
      tick();
      tick();
      check("rst_data", 32'(dout_a), 32'd0);
      check("rst_cnt", 32'(cnt_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd1);
      check("rst_err", 32'(err_a), 32'd0);
      check("rst_done4", 32'(done_b), 32'd1);
      check("rst_data4", 32'(dout_b), 32'd0);
      rst_n = 1'b1;
      tick();

      cap8("b2", 8, 16'hB200, -1, 1'b0);
      check("b2_const", 32'(dout_a), 32'hB2);
      cap8("len3", 3, 16'hC000, -1, 1'b1);
      check("len3_const", 32'(dout_a), 32'h06);
      cap8("len0", 0, 16'h5A00, -1, 1'b0);
      check("len0_cnt", 32'(cnt_a), 32'd8);
      cap8("lenbig", 12, 16'h3C00, -1, 1'b0);
      cap8("abort", 8, 16'hB200, 5, 1'b0);
      check("abort_const", 32'(dout_a), 32'h16);

      read_a = 1'b1;
      din_a  = 1'b1;
      tick();
      read_a = 1'b0;
      check("idle_rd_data", 32'(dout_a), 32'h16);
      check("idle_rd_cnt", 32'(cnt_a), 32'd5);
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      check("idle_ab_busy", 32'(busy_a), 32'd0);
      start_a = 1'b1;
      abort_a = 1'b1;
      len_a   = 4'd8;
      tick();
      start_a = 1'b0;
      abort_a = 1'b0;
      check("st_ab_busy", 32'(busy_a), 32'd0);
      check("st_ab_cnt", 32'(cnt_a), 32'd5);

      start_a = 1'b1;
      len_a   = 4'd8;
      tick();
      start_a = 1'b0;
      for (int k = 0; k < 3; k++) begin
         read_a = 1'b1;
         din_a  = 1'b1;
         tick();
         read_a = 1'b0;
      end
      check("pre_rst_cnt", 32'(cnt_a), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_data", 32'(dout_a), 32'd0);
      check("mid_rst_cnt", 32'(cnt_a), 32'd0);
      check("mid_rst_done", 32'(done_a), 32'd1);
      check("mid_rst_busy", 32'(busy_a), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      cap8("post_rst", 8, 16'hE700, -1, 1'b0);

      cap16("n4321", 4, 16'h4321);
      check("n4321_const", 32'(dout_b), 32'h4321);
      cap16("n2", 2, 16'h00A5);
      cap16("n0", 0, 16'hF00D);

`ifdef SERIAL_CAPTURE_TIMEOUT_EN
      start_a = 1'b1;
      len_a   = 4'd8;
      tick();
      start_a = 1'b0;
      repeat (15) tick();
      check("tmo_pre_err", 32'(err_a), 32'd0);
      check("tmo_pre_busy", 32'(busy_a), 32'd1);
      tick();
      check("tmo_err", 32'(err_a), 32'd1);
      check("tmo_busy", 32'(busy_a), 32'd0);
      check("tmo_done", 32'(done_a), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
